// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter and its FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   BITS_PER_FRAME  = 10;   // start + 8 data + stop

endpackage

// File: rtl/uart_tx_if.sv
// Character strobe / status handshake between the debug-dump formatter and the UART.
interface uart_tx_if;
    logic       txen;
    logic [7:0] datain;
    logic       busy;
    logic       idle;

    modport master (output txen, output datain, input busy, input idle);
    modport slave  (input txen, input datain, output busy, output idle);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock circular byte FIFO; head byte is readable combinationally for same-edge pop.
module fifo_sync #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q;
    logic                  push, pop;

    // Fullness is judged on the count before the edge, so a same-edge pop never frees room.
    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;
endmodule

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter: FIFO-fed shifter with baud and bit counters.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKDIV     = 868,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       txd
);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKDIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(BITS_PER_FRAME - 3);

    state_t              state_q, state_d;
    logic [15:0]         baud_q, baud_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                txd_q, txd_d;
    logic                idle_q, idle_d;
    logic                pop;
    logic [7:0]          fifo_head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full, fifo_empty;

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.txen),
        .wr_data (bus.datain),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    txd_d   = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    txd_d    = shreg_q[0];
                    bitcnt_d = '0;
                    baud_d   = BAUD_RELOAD;
                    state_d  = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bitcnt_q == LAST_BIT) begin
                        txd_d   = UART_IDLE_LEVEL;
                        state_d = S_STOP;
                    end else begin
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                        txd_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_head;
                        txd_d   = 1'b0;
                        baud_d  = BAUD_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                txd_d    = UART_IDLE_LEVEL;
                baud_d   = '0;
                bitcnt_d = '0;
            end
        endcase
    end

    // Staying idle implies nothing was popped, so the FIFO stays empty unless this edge writes.
    assign idle_d = (state_d == S_IDLE) && (fifo_count == '0) && !bus.txen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            txd_q    <= UART_IDLE_LEVEL;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            idle_q   <= idle_d;
        end
    end

    assign txd      = txd_q;
    assign bus.idle = idle_q;
    assign bus.busy = fifo_full;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKDIV=4, DEPTH_LOG2=2 with a sampling line decoder.
module tb_uart_tx;
    localparam int CLKDIV = 4;
    localparam int FRAME  = 10 * CLKDIV;

    logic clk;
    logic rst;
    logic txd;
    int   cyc;
    int   n_cmp;
    int   n_err;

    uart_tx_if bus_if ();

    uart_tx #(.CLKDIV(CLKDIV), .DEPTH_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .txd (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       txen;
        logic [7:0] din;
        int         ncyc;
        logic       txd;
        logic       busy;
        logic       idle;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] dec_q[$];
    int         dec_start_q[$];
    logic [7:0] exp_q[$];
    bit         dec_active;
    int         dec_cnt;
    logic [7:0] dec_sh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic en, input logic [7:0] d);
        bus_if.txen   = en;
        bus_if.datain = d;
        @(posedge clk);
        #1;
        bus_if.txen = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (!bus_if.idle && n < max) begin
            tick(1'b0, 8'h00);
            n++;
        end
        check("wait_idle", {31'd0, bus_if.idle}, 32'd1);
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, dec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
            check(name, {24'd0, dec_q[i]}, {24'd0, exp_q[i]});
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
    endfunction

    // Mid-bit sampler: start detected on the first low sample, then one sample per bit centre.
    always @(negedge clk) begin
        if (rst) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (txd == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
                dec_start_q.push_back(cyc);
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == CLKDIV / 2) begin
                check("dec_start_bit", {31'd0, txd}, 32'd0);
            end else if (dec_cnt == 9 * CLKDIV + CLKDIV / 2) begin
                check("dec_stop_bit", {31'd0, txd}, 32'd1);
                dec_q.push_back(dec_sh);
                dec_active = 1'b0;
            end else if (dec_cnt % CLKDIV == CLKDIV / 2) begin
                dec_sh[dec_cnt / CLKDIV - 1] = txd;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int lows;
        logic [31:0] rv;
        logic [7:0]  a5_bits;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        dec_active = 1'b0;
        bus_if.txen   = 1'b0;
        bus_if.datain = 8'h00;
        rst = 1'b1;
        idle_ticks(2);
        rst = 1'b0;

        check("reset_txd",  {31'd0, txd},         32'd1);
        check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset_idle", {31'd0, bus_if.idle}, 32'd1);
        idle_ticks(2);

        // Single byte A5: per-cycle line/status profile.
        vt.push_back(vec_t'{1'b1, 8'hA5, 1, 1'b1, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b0, 8'h00, 4, 1'b0, 1'b0, 1'b0});
        a5_bits = 8'hA5;
        for (int b = 0; b < 8; b++)
            vt.push_back(vec_t'{1'b0, 8'h00, 4, a5_bits[b], 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b0, 8'h00, 1, 1'b1, 1'b0, 1'b1});
        vt.push_back(vec_t'{1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b1});
        dec_q.delete();
        for (int v = 0; v < vt.size(); v++) begin
            for (int c = 0; c < vt[v].ncyc; c++) begin
                tick(vt[v].txen, vt[v].din);
                check($sformatf("vec%0d_txd", v),  {31'd0, txd},         {31'd0, vt[v].txd});
                check($sformatf("vec%0d_busy", v), {31'd0, bus_if.busy}, {31'd0, vt[v].busy});
                check($sformatf("vec%0d_idle", v), {31'd0, bus_if.idle}, {31'd0, vt[v].idle});
            end
        end
        exp_q = '{8'hA5};
        check_stream("single_stream");

        // Back-to-back: three frames with no gap, 120 cycles of line activity.
        dec_q.delete();
        dec_start_q.delete();
        tick(1'b1, 8'h50);
        n0 = cyc;
        tick(1'b1, 8'h2C);
        tick(1'b1, 8'h0A);
        wait_idle(300);
        check("b2b_total", cyc - n0, 3 * FRAME + 1);
        check("b2b_gap01", dec_start_q[1] - dec_start_q[0], FRAME);
        check("b2b_gap12", dec_start_q[2] - dec_start_q[1], FRAME);
        exp_q = '{8'h50, 8'h2C, 8'h0A};
        check_stream("b2b_stream");
        idle_ticks(3);

        // Overflow plus simultaneous push/pop at stop-bit end.
        dec_q.delete();
        tick(1'b1, 8'hB0);                          // edge N
        tick(1'b0, 8'h00);                          // N+1 pop
        tick(1'b1, 8'h01);
        tick(1'b1, 8'h02);
        tick(1'b1, 8'h03);                          // N+4
        check("ovf_busy_n4", {31'd0, bus_if.busy}, 32'd0);
        tick(1'b1, 8'h04);                          // N+5, fourth accepted write
        check("ovf_busy_n5", {31'd0, bus_if.busy}, 32'd1);
        tick(1'b1, 8'h05);                          // N+6, dropped
        check("ovf_busy_n6", {31'd0, bus_if.busy}, 32'd1);
        check("ovf_count_n6", {29'd0, dut.u_fifo.count}, 32'd4);
        idle_ticks(34);                             // through N+40
        check("ovf_busy_n40", {31'd0, bus_if.busy}, 32'd1);
        tick(1'b1, 8'h06);                          // N+41: pop with full FIFO, push dropped
        check("sim_busy_n41", {31'd0, bus_if.busy}, 32'd0);
        check("sim_count_n41", {29'd0, dut.u_fifo.count}, 32'd3);
        idle_ticks(40);                             // through N+81 pop
        check("sim_count_n81", {29'd0, dut.u_fifo.count}, 32'd2);
        idle_ticks(39);
        tick(1'b1, 8'h07);                          // N+121: push and pop together
        check("sim_count_n121", {29'd0, dut.u_fifo.count}, 32'd2);
        wait_idle(400);
        exp_q = '{8'hB0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07};
        check_stream("ovf_stream");
        idle_ticks(3);

        // Formatter handshake: strobe, then poll busy before the next character.
        dec_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h50);
        for (int r = 0; r < 32; r++) begin
            rv = (r * 32'h0101_0101) ^ 32'hDEAD_BEEF;
            for (int h = 7; h >= 0; h--) exp_q.push_back(hexc(rv[h*4 +: 4]));
            exp_q.push_back(8'h2C);
        end
        exp_q.push_back(8'h0A);
        for (int i = 0; i < exp_q.size(); i++) begin
            int n;
            n = 0;
            while (bus_if.busy && n < 2 * FRAME) begin
                tick(1'b0, 8'h00);
                n++;
            end
            if (bus_if.busy) check("fmt_busy_timeout", {31'd0, bus_if.busy}, 32'd0);
            tick(1'b1, exp_q[i]);
        end
        wait_idle(6 * FRAME);
        check_stream("fmt_stream");
        idle_ticks(3);

        // Reset during data bit 3 with two bytes queued.
        dec_q.delete();
        tick(1'b1, 8'hC3);                          // N
        tick(1'b1, 8'h11);                          // N+1 (pop C3)
        tick(1'b1, 8'h22);                          // N+2
        idle_ticks(15);                             // through N+17, bit 3 started
        rst = 1'b1;
        tick(1'b0, 8'h00);                          // N+18
        rst = 1'b0;
        check("rst_txd",  {31'd0, txd},         32'd1);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_idle", {31'd0, bus_if.idle}, 32'd1);
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b0, 8'h00);
            if (txd == 1'b0) lows++;
        end
        check("rst_quiet_lows", lows, 0);
        check("rst_no_frames", dec_q.size(), 0);
        tick(1'b1, 8'h3C);
        wait_idle(2 * FRAME);
        exp_q = '{8'h3C};
        check_stream("rst_after_stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter, 8N1, LSB first, with a small transmit FIFO.
- Sits directly downstream of the debug-dump formatter. It consumes that block's character strobe (txen + datain) and returns the busy flag the formatter polls before sending the next character.
- Drives the board TX pin.

Parameters:
- CLKDIV, 868: clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- DEPTH_LOG2, 2: FIFO depth = 2**DEPTH_LOG2 entries (default 4). Legal range 1..6.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- txen  input  1  one-cycle write strobe; datain captured on the same posedge.
- datain  input  8  byte to transmit.
- busy  output  1  registered; high when FIFO holds 2**DEPTH_LOG2 bytes (cannot accept).
- idle  output  1  registered; high when FIFO empty and shifter in S_IDLE.
- txd  output  1  serial line, registered; idle level 1.

Behaviour:
- Reset (rst=1 at posedge), including mid-frame:
  - txd=1, busy=0, idle=1.
  - FIFO pointers and count cleared; state S_IDLE.
  - Baud and bit counters cleared.
  - Takes effect on that edge; any frame in progress is aborted (truncated frame on the line is accepted).
  - rst has priority over txen.
- Write:
  - At posedge with txen=1 and count<DEPTH (count before the edge), datain is stored and count increments.
  - txen while count==DEPTH: byte dropped silently, no state change.
  - A simultaneous shifter pop in that cycle does NOT make room for that write.
- busy/idle update on the same edge that samples txen/pop, so they are valid the next cycle:
  - busy_next = (count_next==DEPTH).
  - idle_next = (count_next==0) && (state_next==S_IDLE).
- FIFO:
  - Circular buffer; read/write pointers of DEPTH_LOG2 bits wrap naturally.
  - count is DEPTH_LOG2+1 bits.
  - Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- Shifter FSM (baud counter reloads CLKDIV-1 and counts down; a bit ends when the counter reaches 0):
  - S_IDLE: txd=1. If count>0: pop head into shift register, txd<=0, state<=S_START.
  - S_START: hold txd=0 for CLKDIV cycles. Then txd<=shreg[0], bitcnt<=0, state<=S_DATA.
  - S_DATA: each bit held CLKDIV cycles. At bit end shift right, bitcnt++, txd<=next bit. After bit 7, txd<=1 and state<=S_STOP.
  - S_STOP: txd=1 for CLKDIV cycles. At end:
    - if count>0, pop and go straight to S_START (no idle gap; txd<=0 same edge);
    - else state<=S_IDLE.
- Latency from an empty, idle block:
  - txen sampled at edge N.
  - Pop at edge N+1.
  - txd low from edge N+1.
  - Frame occupies exactly 10*CLKDIV cycles.
- Formatter compatibility: the formatter checks busy one cycle after its strobe. busy is therefore never asserted late.
- Undefined FSM state: recover to S_IDLE with txd=1.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings S_IDLE/S_START/S_DATA/S_STOP (2 bits);
  - UART_IDLE_LEVEL=1'b1;
  - frame constant BITS_PER_FRAME=10.
- One natural sub-module, fifo_sync:
  - ports clk, rst, wr_en, wr_data[7:0], rd_en, rd_data, count, full, empty;
  - parameter DEPTH_LOG2.
- uart_tx instantiates fifo_sync and holds the baud/bit counters and FSM.

Test Plan (benches use CLKDIV=4, DEPTH_LOG2=2):
- Single byte: txen with datain=8'hA5 at edge N.
  - txd=0 for cycles N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
  - Then txd=1 for 4 cycles.
  - idle returns to 1 at edge N+41.
- Back-to-back: write "P", ",", "\n" (8'h50, 8'h2C, 8'h0A) on consecutive cycles.
  - Three frames on txd with no idle cycle between stop bit and next start bit.
  - Total 120 cycles.
  - A sampling UART model decodes 50, 2C, 0A.
- Full/overflow: while frame 1 is shifting, write 5 more bytes (01..05) on consecutive cycles.
  - busy=1 the cycle after the 4th accepted write.
  - 5th byte dropped.
  - Decoded stream excludes it.
  - busy drops exactly one cycle after the pop that frees a slot.
- Formatter handshake: drive the debug-dump formatter model (strobe, then poll busy next cycle) for a full 32-register packet.
  - Decoded text = "P" + 32×(8 hex chars + ",") + "\n".
  - No byte lost.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 with 2 bytes queued.
  - Next cycle: txd=1, busy=0, idle=1.
  - No further frames emitted.
  - A new write afterwards transmits normally.
- Simultaneous events: push with count=DEPTH on the same edge as a stop-bit-end pop.
  - Write dropped; count goes 4→3.
  - With count=2, simultaneous push and pop leaves count=2.
